// File: rtl/lsu_pkg.sv
// Shared definitions for the data-side load/store unit: funct3 encodings,
// FSM state type and the request legality checks.
package lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_t;

    // Loads allow B/H/W/BU/HU; stores allow only B/H/W.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we) begin
            return f3 > 3'b010;
        end
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // Size lives in funct3[1:0]; unsigned variants share the signed size.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return lo[0];
            2'b10:   return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load formatter: picks the byte/halfword lane addressed by
// addr[1:0] and applies sign or zero extension according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by extension.
    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            LSU_B:   data = {{24{byte_sel[7]}}, byte_sel};
            LSU_H:   data = {{16{half_sel[15]}}, half_sel};
            LSU_BU:  data = {24'd0, byte_sel};
            LSU_HU:  data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit spanning MEMPREP/MEMEX. One operation at a time:
// accept -> check -> DTCM request/grant -> (load) wait for rvalid -> respond.
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; mem_req is held with stable fields until the
// edge where mem_gnt is high; rsp_valid is a single-cycle pulse with no
// backpressure.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_rd,
    output logic              req_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              rsp_valid,
    output logic              rsp_we_rd,
    output logic [3:0]        rsp_rd,
    output logic [31:0]       rsp_rdata,
    output logic              fault,
    output logic [1:0]        dbg_state
);

    lsu_state_t  state;
    logic [2:0]  op_f3;
    logic [1:0]  op_lo;
    logic        accept;
    logic        req_fault;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] load_data;

    assign req_ready = (state == IDLE) && rst;
    assign accept    = req_valid && req_ready;
    assign dbg_state = state;

    // Legality check and store lane preparation for the incoming request.
    always_comb begin
        req_fault = f3_illegal(req_we, req_funct3)
                  | misaligned(req_funct3, req_addr[1:0])
                  | (|req_addr[31:ADDR_W]);
        case (req_funct3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << req_addr[1:0];
                wdata_next = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_next    = 4'b0011 << req_addr[1:0];
                wdata_next = {2{req_wdata[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = req_wdata;
            end
        endcase
    end

    lsu_load_align u_align (
        .rdata   (mem_rdata),
        .addr_lo (op_lo),
        .funct3  (op_f3),
        .data    (load_data)
    );

    // Control FSM with registered DTCM request and response outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            op_f3     <= '0;
            op_lo     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_we_rd <= 1'b0;
            rsp_rd    <= '0;
            rsp_rdata <= '0;
            fault     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_we_rd <= 1'b0;
            rsp_rdata <= '0;
            fault     <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        rsp_rd <= req_rd;
                        if (req_fault) begin
                            rsp_valid <= 1'b1;
                            fault     <= 1'b1;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= req_addr[ADDR_W-1:2];
                            mem_be    <= be_next;
                            mem_wdata <= wdata_next;
                            op_f3     <= req_funct3;
                            op_lo     <= req_addr[1:0];
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            rsp_valid <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        rsp_valid <= 1'b1;
                        rsp_we_rd <= 1'b1;
                        rsp_rdata <= load_data;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-side load/store unit for the RV32E core. It spans the MEMPREP and MEMEX pipeline stages and accepts one memory operation at a time from the EX-MEMPREP register. It issues a request/grant transaction to the data TCM, then returns aligned and extended load data, or store completion, to the MEMEX-WB register. `req_ready` low is the stall source for MEMPREP and everything upstream of it.

## Interface
- `ADDR_W`, default 12: DTCM byte-address width. Any address with bits [31:ADDR_W] nonzero faults.
- `clk  in  1`: core clock; the block's only clock.
- `rst  in  1`: synchronous, active-low reset.
- `req_valid  in  1`: MEMPREP holds a load or store.
- `req_we  in  1`: 1 = store, 0 = load.
- `req_funct3  in  3`: RV32 funct3. Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101. Stores: SB 000, SH 001, SW 010.
- `req_addr  in  32`: effective address (`alu_result_MEMPREP`).
- `req_wdata  in  32`: store data (rs2).
- `req_rd  in  4`: load destination register.
- `req_ready  out  1`: high only in IDLE with `rst` high. Low means stall MEMPREP.
- `mem_req  out  1`: DTCM request, held until granted.
- `mem_we  out  1`: store request.
- `mem_addr  out  ADDR_W-2`: word address, taken from addr[ADDR_W-1:2].
- `mem_be  out  4`: byte enables.
- `mem_wdata  out  32`: lane-replicated store data.
- `mem_gnt  in  1`: DTCM accepted the request.
- `mem_rvalid  in  1`: read data valid. Arrives no earlier than one cycle after `mem_gnt`.
- `mem_rdata  in  32`: read word.
- `rsp_valid  out  1`: one-cycle completion pulse.
- `rsp_we_rd  out  1`: write `rsp_rd`. Set only for a successful load.
- `rsp_rd  out  4`: destination register.
- `rsp_rdata  out  32`: formatted load data. 0 for stores and faults.
- `fault  out  1`: misaligned, out-of-range, or illegal funct3. Only valid alongside `rsp_valid`.

## Operation
- FSM states: IDLE, REQ, WAIT.
- **IDLE, request accepted** (`req_valid & req_ready`): capture the operation and check it.
  - Fault conditions:
    - funct3 is illegal for the direction: loads 011/110/111; stores with any value ≥ 011.
    - Halfword access with addr[0] set.
    - Word access with addr[1:0] ≠ 00.
    - Out-of-range address.
  - On fault: next cycle `rsp_valid=1`, `fault=1`, `rsp_we_rd=0`. State stays IDLE and no `mem_req` is issued.
  - Otherwise: go to REQ.
- **REQ**: `mem_req=1`, with `mem_addr`, `mem_be`, `mem_we`, `mem_wdata` registered and held stable until `mem_gnt`.
  - On `mem_gnt` with a store: `rsp_valid` next cycle, go to IDLE.
  - On `mem_gnt` with a load: go to WAIT.
  - `mem_rvalid` in REQ is ignored.
- **WAIT**: on `mem_rvalid`, register the formatted data. `rsp_valid=1` and `rsp_we_rd=1` next cycle, go to IDLE.
- **Byte enables**:
  - SB: 0001 << addr[1:0].
  - SH: 0011 << addr[1:0].
  - SW: 1111.
- **Store data**: SB replicates wdata[7:0] into all 4 lanes, SH replicates wdata[15:0] into both halves, SW passes wdata through.
- **Load data**:
  - Select the byte/halfword lane using the captured addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- **Response outputs**: `rsp_*` and `fault` are registered and valid for exactly one cycle. `rsp_rd` is captured at acceptance.
- **IDLE, nothing accepted**: `req_valid` low or `rst` low; no state change.

## Timing
- **Reset values**:
  - state IDLE.
  - `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata` all 0.
  - `rsp_valid`, `rsp_we_rd`, `rsp_rd`, `rsp_rdata`, `fault` all 0.
  - `req_ready` 0 while `rst` is low.
- **Latency**, counted from the accept edge (cycle 0):
  - Fault response: cycle 1.
  - Store with immediate grant: `mem_req` in cycle 1, response in cycle 2.
  - Load with immediate grant and rvalid: grant in cycle 1, rvalid in cycle 2, response in cycle 3.
- **Throughput**: a new request may be accepted in the same cycle `rsp_valid` is high, because the state is already IDLE. There is no downstream backpressure.
- **Grant/rvalid stalls**: every stall cycle extends latency by one. `req_ready` stays low throughout.
- **Reset mid-operation**:
  - The transaction is abandoned and state returns to IDLE.
  - `mem_req` drops on the next edge and no response is produced.
  - A late `mem_rvalid` arriving in IDLE is ignored.

## Structure
- Package `lsu_pkg`:
  - funct3 constants `LSU_B`, `LSU_H`, `LSU_W`, `LSU_BU`, `LSU_HU`.
  - State enum `lsu_state_t` {IDLE, REQ, WAIT}.
- Sub-module `lsu_load_align`: combinational lane select plus sign/zero extension from `mem_rdata`, addr[1:0] and funct3. Reusable for a future ITCM data port.
- The FSM, alignment/fault check, byte-enable and replication logic live in `load_store_unit`.

## Test plan
1. SW to 0x10 with data 0xDEADBEEF, `mem_gnt` tied high -> cycle 1: `mem_addr`=4, `mem_be`=1111, `mem_wdata`=0xDEADBEEF. Cycle 2: `rsp_valid`=1, `rsp_we_rd`=0, `fault`=0.
2. SB to 0x13 with data 0x000000A5 -> `mem_be`=1000, `mem_wdata`=0xA5A5A5A5. SH to 0x12 with data 0x1234 -> `mem_be`=1100, `mem_wdata`=0x12341234.
3. `mem_rdata`=0x1280FF34, all loads with rd=5:
   - LB @0x12 -> `rsp_rdata`=0xFFFFFF80, `rsp_rd`=5, `rsp_we_rd`=1.
   - LBU @0x12 -> 0x00000080.
   - LHU @0x12 -> 0x00001280.
   - LH @0x10 -> 0xFFFFFF34.
4. Faulting requests -> cycle 1: `rsp_valid`=1, `fault`=1, no `mem_req` ever:
   - LW @0x06.
   - LH @0x11.
   - LW @0x1000 with `ADDR_W`=12.
   - funct3 011 load.
5. LW with `mem_gnt` delayed 3 cycles and `mem_rvalid` delayed 2 more -> `mem_*` stable during REQ, `req_ready`=0 throughout, `rsp_valid` exactly one cycle after `mem_rvalid`. A back-to-back request is accepted on the `rsp_valid` cycle.
6. `rst` low for one cycle while in WAIT, then `mem_rvalid` pulses -> `mem_req`=0, state IDLE, `rsp_valid` never asserts, `req_ready` returns high the cycle after `rst` rises.
